// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS funct codes and the mul/div unit state encoding
package mips_pkg;

    localparam logic [5:0] FUNCT_SLL   = 6'b000000;
    localparam logic [5:0] FUNCT_SRL   = 6'b000010;
    localparam logic [5:0] FUNCT_SRA   = 6'b000011;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} muldiv_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative mult/div with HI/LO; define MULDIV_SIGNED_EN for signed mult/div
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             divzero
);
    localparam int CW = $clog2(WIDTH + 1);

    muldiv_state_t      state;
    logic [WIDTH-1:0]   hi, lo, opb;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_lo, neg_hi;
    logic               sa, sb, dz;
    logic [WIDTH-1:0]   mag_a, mag_b, rsub, quo, rem;
    logic [WIDTH:0]     madd, rsh;
    logic               ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    assign result = funct == FUNCT_MFHI ? hi : lo;

    // sign flags and magnitudes of an incoming operand pair
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        sa = (funct == FUNCT_MULT || funct == FUNCT_DIV) && srca[WIDTH-1];
        sb = (funct == FUNCT_MULT || funct == FUNCT_DIV) && srcb[WIDTH-1];
`else
        sa = 1'b0;
        sb = 1'b0;
`endif
        mag_a = sa ? -srca : srca;
        mag_b = sb ? -srcb : srcb;
        dz = srcb == '0;
    end

    // one shift-add / restoring-divide step and the final sign fixup
    always_comb begin
        madd = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
        mul_next = {madd, acc[WIDTH-1:1]};
        rsh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge = rsh >= {1'b0, opb};
        rsub = rsh[WIDTH-1:0] - opb;
        div_next = ge ? {rsub, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
        prod = neg_lo ? -acc : acc;
        quo = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // control FSM, shared accumulator/counter and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            acc     <= '0;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    case (funct)
                        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                            // a zero divisor keeps the raw dividend so it falls out as HI
                            is_div <= funct[1];
                            state  <= funct[1] ? DIV : MUL;
                            acc    <= {{WIDTH{1'b0}}, funct[1] ? (dz ? srca : mag_a) : mag_b};
                            opb    <= funct[1] ? mag_b : mag_a;
                            neg_lo <= (sa ^ sb) && !(funct[1] && dz);
                            neg_hi <= funct[1] && sa && !dz;
                            cnt    <= CW'(WIDTH);
                            busy   <= 1'b1;
                            if (funct[1]) divzero <= 1'b0;
                        end
                        FUNCT_MTHI: begin
                            hi   <= srca;
                            done <= 1'b1;
                        end
                        FUNCT_MTLO: begin
                            lo   <= srca;
                            done <= 1'b1;
                        end
                        FUNCT_MFHI, FUNCT_MFLO: done <= 1'b1;
                        default: ;
                    endcase
                end
                MUL, DIV: begin
                    acc <= state == MUL ? mul_next : div_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIXUP;
                end
                FIXUP: begin
                    {hi, lo} <= is_div ? {rem, quo} : prod;
                    if (is_div) divzero <= opb == '0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit against an arithmetic HI/LO model
module tb_mul_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [5:0]   funct = FUNCT_MFLO;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic         busy, done, divzero;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;
    int ndone = 0;

    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;
    logic         dz_m = 1'b0;
    exp_t         sb[$];
    exp_t         mon_e;

    logic [W-1:0] sp [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h2};
    logic [5:0]   fl [10] = '{FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO, FUNCT_MULT,
                              FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, 6'b100000, 6'b011100};

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct), .srca(srca), .srcb(srcb),
        .busy(busy), .done(done), .result(result), .divzero(divzero)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_md(input logic [5:0] f);
        return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    endfunction

    function automatic logic is_valid(input logic [5:0] f);
        return is_md(f) || f inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO};
    endfunction

    function automatic logic [W-1:0] pick();
        return ($urandom_range(0, 2) == 0) ? sp[$urandom_range(0, 4)] : W'($urandom);
    endfunction

    task automatic model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic        sgn;
        logic [63:0] p;
        int          x, y;
`ifdef MULDIV_SIGNED_EN
        sgn = (f == FUNCT_MULT || f == FUNCT_DIV);
`else
        sgn = 1'b0;
`endif
        x = $signed(a);
        y = $signed(b);
        case (f)
            FUNCT_MTHI: hi_m = a;
            FUNCT_MTLO: lo_m = a;
            FUNCT_MULT, FUNCT_MULTU: begin
                if (sgn) p = longint'(x) * longint'(y);
                else p = 64'(a) * 64'(b);
                hi_m = p[63:32];
                lo_m = p[31:0];
            end
            FUNCT_DIV, FUNCT_DIVU: begin
                dz_m = (b == 0);
                if (b == 0) begin
                    lo_m = '1;
                    hi_m = a;
                end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = a;
                    hi_m = '0;
                end else if (sgn) begin
                    lo_m = x / y;
                    hi_m = x % y;
                end else begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
        int   n, bc, d0;
        logic ok, md;
        @(negedge clk);
        funct = f;
        srca = a;
        srcb = b;
        start = 1'b1;
        ok = is_valid(f);
        md = is_md(f);
        if (ok) begin
            model(f, a, b);
            sb.push_back('{f == FUNCT_MFHI ? hi_m : lo_m, dz_m});
        end
        d0 = ndone;
        @(posedge clk);
        #1 start = 1'b0;
        if (!ok) begin
            repeat (3) @(negedge clk);
            #1 chk("ignored_no_done", 64'(ndone), 64'(d0));
            return;
        end
        n = 0;
        bc = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
            if (n == 1 && (f == FUNCT_DIV || f == FUNCT_DIVU)) chk("divzero_clear", 64'(divzero), 64'(0));
            if (done) break;
            start = (n == poke);
            if (n == poke) begin
                srca = $urandom;
                srcb = $urandom;
            end
        end
        start = 1'b0;
        #1;
        chk("done_latency", 64'(n), md ? 64'(W + 2) : 64'(1));
        chk("busy_cycles", 64'(bc), md ? 64'(W + 1) : 64'(0));
        chk("one_done", 64'(ndone), 64'(d0 + 1));
    endtask

    task automatic reset_mid();
        @(negedge clk);
        funct = FUNCT_MULT;
        srca = $urandom;
        srcb = $urandom;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        sb.delete();
        hi_m = '0;
        lo_m = '0;
        dz_m = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_lo", 64'(result), 64'(0));
        funct = FUNCT_MFHI;
        #1 chk("abort_hi", 64'(result), 64'(0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    // monitor: every done pops one expected response
    always @(negedge clk) begin
        if (!reset && done) begin
            ndone++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                mon_e = sb.pop_front();
                chk("result", 64'(result), 64'(mon_e.res));
                chk("divzero", 64'(divzero), 64'(mon_e.dz));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_divzero", 64'(divzero), 64'(0));
        chk("reset_lo", 64'(result), 64'(0));
        funct = FUNCT_MFHI;
        #1 chk("reset_hi", 64'(result), 64'(0));
        reset = 1'b0;

        do_op(FUNCT_MULT, 32'd7, 32'hFFFF_FFFD, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_DIVU, 32'd7, 32'd2, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_DIVU, 32'h0000_000A, 32'd0, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_DIVU, 32'd4, 32'd2, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_MTHI, 32'h0000_1234, 0, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_MULT, 32'h0001_0003, 32'h0000_0105, 5);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(6'b100000, 32'hDEAD_BEEF, 32'h1, 0);
        do_op(FUNCT_MFLO, 0, 0, 0);
        do_op(FUNCT_MTLO, 32'hCAFE_F00D, 0, 0);
        do_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd0, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);
        do_op(FUNCT_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);

        reset_mid();
        do_op(FUNCT_MULT, 32'd3, 32'd5, 0);
        do_op(FUNCT_MFHI, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [5:0] f;
            f = fl[$urandom_range(0, 9)];
            do_op(f, pick(), pick(), is_md(f) ? int'($urandom_range(0, W)) : 0);
            if (is_md(f)) do_op(FUNCT_MFHI, 0, 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
